cardinal_nic_fifo: RTL and testbench
====================================

CARDINAL_NIC_FIFO -- requirements
Module: cardinal_nic_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64, packet width in bits; SHALL be at least 8.
REQ-002 Parameter DEPTH, default 4, entries per channel FIFO; SHALL be a power of two, at least 2.
REQ-003 Derived CW = $clog2(DEPTH)+1, occupancy counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 addr  input  2  register select: 00 input data, 01 input status, 10 output data, 11 output status.
REQ-007 d_in  input  DATA_WIDTH  packet from PE.
REQ-008 d_out  output  DATA_WIDTH  register read data.
REQ-009 nicEn  input  1  NIC access enable.
REQ-010 nicEnWr  input  1  write qualifier; write when nicEn=1, read when nicEn=1 and nicEnWr=0.
REQ-011 net_si  input  1  router send strobe, input channel.
REQ-012 net_ri  output  1  NIC ready, input channel.
REQ-013 net_di  input  DATA_WIDTH  packet from router.
REQ-014 net_so  output  1  NIC send strobe, output channel.
REQ-015 net_ro  input  1  router ready, output channel.
REQ-016 net_do  output  DATA_WIDTH  packet to router.
REQ-017 net_polarity  input  1  router cycle polarity.

Function
REQ-018 Two independent circular FIFOs of DEPTH entries (input, output), each with read pointer, write pointer and CW-bit count; pointers wrap from DEPTH-1 to 0.
REQ-019 net_ri SHALL equal (input count != DEPTH), combinational; it SHALL NOT consider a same-cycle processor pop.
REQ-020 Input push when net_si=1 and net_ri=1: net_di written at write pointer on that edge; net_si while net_ri=0 is ignored.
REQ-021 Processor pop: nicEn=1, nicEnWr=0, addr=00, input count>0 -> d_out = input head, combinational; pointer advances on that edge.
REQ-022 Read of addr 00 with input empty: d_out = 0, no pointer change, sticky underflow flag set.
REQ-023 Status 01: d_out[DATA_WIDTH-1] = input non-empty, [DATA_WIDTH-2] = underflow flag, [CW-1:0] = input count, other bits 0; the read clears underflow on that edge.
REQ-024 Processor push: nicEn=1, nicEnWr=1, addr=10; accepted when output count<DEPTH, or when count=DEPTH and an output pop occurs in the same cycle.
REQ-025 Push otherwise full: d_in dropped, sticky overflow flag set; writes with addr != 10 have no effect.
REQ-026 Status 11: d_out[DATA_WIDTH-1] = output full, [DATA_WIDTH-2] = overflow flag, [CW-1:0] = output count, other bits 0; the read clears overflow on that edge.
REQ-027 d_out = 0 whenever nicEn=0 or nicEnWr=1; read of addr 10 returns 0.
REQ-028 net_do SHALL always equal output FIFO head; undefined content irrelevant when empty but SHALL be 0 after reset.
REQ-029 net_so = (output count>0) and net_ro and (head[DATA_WIDTH-1] != net_polarity), combinational; a pop occurs on every edge where net_so=1.
REQ-030 Head whose VC bit equals net_polarity SHALL wait; no reordering, no bypass of head.
REQ-031 Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance; a push into an empty FIFO is not visible at the head until the next cycle (no fall-through).
REQ-032 Counts SHALL never exceed DEPTH nor go below 0 under any input combination.

Reset
REQ-033 While reset=0: all pointers, counts, overflow and underflow flags = 0; storage cleared to 0; net_ri=1, net_so=0, net_do=0; d_out=0 regardless of nicEn.
REQ-034 Reset asserted mid-transfer SHALL discard all queued packets immediately, without waiting for a clock edge; after release, the first edge is a normal operating cycle.

Verification
REQ-035 DEPTH=4: push 0x8000_0000_0000_00A1 via addr 10 while net_polarity=0, net_ro=1 -> net_so=1 on the cycle after the push, net_do = that value, output count returns 0.
REQ-036 Five pushes via addr 10 with net_ro=0 -> count=4, status 11 reads MSB=1, bit62=1, low bits=4; second status read shows bit62=0.
REQ-037 Four router pushes 1,2,3,4 with net_si=1 -> net_ri=0 after fourth; four addr-00 reads return 1,2,3,4 in order; a fifth read returns 0 and sets underflow.
REQ-038 Head VC bit=1, net_polarity=1 -> net_so=0; toggle polarity to 0 -> net_so=1 that cycle, pop on edge.
REQ-039 Output full, net_so=1 and processor push in same cycle -> push accepted, count stays 4, overflow stays 0.
REQ-040 Reset pulsed low between edges with 3 entries queued -> counts 0, net_so=0, net_ri=1 immediately; no stale packet emerges after release.

Source files
------------

// File: rtl/cardinal_nic_fifo.sv
// cardinal_nic_fifo
//   Network interface between one processing element (PE) and a router.
//   Holds two independent circular FIFOs of DEPTH packets:
//     input FIFO  : filled by the router (net_si/net_ri/net_di),
//                   drained by PE reads of register 00.
//     output FIFO : filled by PE writes of register 10,
//                   drained by the router (net_so/net_ro/net_do).
//   The router alternates even/odd cycles (net_polarity).
//   A packet is sent only when its virtual-channel bit (MSB) differs
//   from the current polarity.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   addr         PE register select: 00 in data, 01 in status,
//                10 out data, 11 out status
//   d_in         PE write data
//   d_out        PE read data (combinational)
//   nicEn        PE access enable
//   nicEnWr      1 = write, 0 = read
//   net_si       router -> NIC send strobe
//   net_ri       NIC ready to accept from router
//   net_di       router -> NIC packet
//   net_so       NIC -> router send strobe
//   net_ro       router ready to accept from NIC
//   net_do       NIC -> router packet (output FIFO head)
//   net_polarity router cycle polarity
module cardinal_nic_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  localparam int CW        = $clog2(DEPTH) + 1,
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  logic [DATA_WIDTH-1:0] in_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] in_mem_d  [DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_d [DEPTH];
  logic [PW-1:0] in_rd_q, in_rd_d, in_wr_q, in_wr_d;
  logic [PW-1:0] out_rd_q, out_rd_d, out_wr_q, out_wr_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic          underflow_q, underflow_d, overflow_q, overflow_d;

  logic pe_rd, pe_wr;
  logic in_push, in_pop, in_empty_rd;
  logic out_push_req, out_push, out_pop;
  logic [DATA_WIDTH-1:0] in_head, out_head;

  function automatic logic [DATA_WIDTH-1:0] status_word(
    input logic          top,
    input logic          flag,
    input logic [CW-1:0] cnt
  );
    logic [DATA_WIDTH-1:0] w;
    w                 = '0;
    w[DATA_WIDTH-1]   = top;
    w[DATA_WIDTH-2]   = flag;
    w[CW-1:0]         = cnt;
    return w;
  endfunction

  assign in_head  = in_mem_q[in_rd_q];
  assign out_head = out_mem_q[out_rd_q];

  assign pe_rd = nicEn && !nicEnWr;
  assign pe_wr = nicEn && nicEnWr;

  // net_ri deliberately ignores a same-cycle PE pop.
  assign net_ri      = (in_cnt_q != CW'(DEPTH));
  assign in_push     = net_si && net_ri;
  assign in_pop      = pe_rd && (addr == 2'b00) && (in_cnt_q != '0);
  assign in_empty_rd = pe_rd && (addr == 2'b00) && (in_cnt_q == '0);

  assign net_so   = (out_cnt_q != '0) && net_ro &&
                    (out_head[DATA_WIDTH-1] != net_polarity);
  assign net_do   = out_head;
  assign out_pop  = net_so;

  // A full output FIFO still accepts a push when the router pops this cycle.
  assign out_push_req = pe_wr && (addr == 2'b10);
  assign out_push     = out_push_req && ((out_cnt_q != CW'(DEPTH)) || out_pop);

  always_comb begin
    d_out = '0;
    if (reset && pe_rd) begin
      case (addr)
        2'b00:   d_out = (in_cnt_q != '0) ? in_head : '0;
        2'b01:   d_out = status_word(in_cnt_q != '0, underflow_q, in_cnt_q);
        2'b11:   d_out = status_word(out_cnt_q == CW'(DEPTH), overflow_q, out_cnt_q);
        default: d_out = '0;
      endcase
    end
  end

  always_comb begin
    in_mem_d  = in_mem_q;
    out_mem_d = out_mem_q;
    in_rd_d   = in_rd_q;
    in_wr_d   = in_wr_q;
    out_rd_d  = out_rd_q;
    out_wr_d  = out_wr_q;
    in_cnt_d  = in_cnt_q + CW'(in_push) - CW'(in_pop);
    out_cnt_d = out_cnt_q + CW'(out_push) - CW'(out_pop);
    underflow_d = underflow_q;
    overflow_d  = overflow_q;

    if (in_push) begin
      in_mem_d[in_wr_q] = net_di;
      in_wr_d           = in_wr_q + 1'b1;
    end
    if (in_pop)  in_rd_d = in_rd_q + 1'b1;

    if (out_push) begin
      out_mem_d[out_wr_q] = d_in;
      out_wr_d            = out_wr_q + 1'b1;
    end
    if (out_pop) out_rd_d = out_rd_q + 1'b1;

    // Set and clear are on different addresses, so they never collide.
    if (in_empty_rd)                          underflow_d = 1'b1;
    else if (pe_rd && (addr == 2'b01))        underflow_d = 1'b0;
    if (out_push_req && !out_push)            overflow_d  = 1'b1;
    else if (pe_rd && (addr == 2'b11))        overflow_d  = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_mem_q    <= '{default: '0};
      out_mem_q   <= '{default: '0};
      in_rd_q     <= '0;
      in_wr_q     <= '0;
      out_rd_q    <= '0;
      out_wr_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      in_mem_q    <= in_mem_d;
      out_mem_q   <= out_mem_d;
      in_rd_q     <= in_rd_d;
      in_wr_q     <= in_wr_d;
      out_rd_q    <= out_rd_d;
      out_wr_q    <= out_wr_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
// Directed bench for cardinal_nic_fifo (DATA_WIDTH=64, DEPTH=4).
module tb_cardinal_nic_fifo;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in;
  logic [63:0] d_out;
  logic        nicEn;
  logic        nicEnWr;
  logic        net_si;
  logic        net_ri;
  logic [63:0] net_di;
  logic        net_so;
  logic        net_ro;
  logic [63:0] net_do;
  logic        net_polarity;

  int n_vec  = 0;
  int n_miss = 0;

  cardinal_nic_fifo #(.DATA_WIDTH(64), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicEnWr(nicEnWr), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; leaves time 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Combinational register read that is withdrawn before any edge.
  task automatic peek(input logic [1:0] a, output logic [63:0] v);
    logic       s_en, s_wr;
    logic [1:0] s_a;
    s_en = nicEn; s_wr = nicEnWr; s_a = addr;
    nicEn = 1'b1; nicEnWr = 1'b0; addr = a;
    #1;
    v = d_out;
    nicEn = s_en; nicEnWr = s_wr; addr = s_a;
  endtask

  task automatic idle();
    nicEn = 1'b0; nicEnWr = 1'b0; addr = 2'b00; net_si = 1'b0;
  endtask

  logic [63:0] v;
  logic [63:0] drain_exp [4];

  initial begin
    reset = 1'b0; addr = 2'b01; d_in = '0; nicEn = 1'b1; nicEnWr = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
    #2;
    check_vec("rst_dout",   d_out,  64'h0);
    check_vec("rst_net_ri", {63'h0, net_ri}, 64'h1);
    check_vec("rst_net_so", {63'h0, net_so}, 64'h0);
    check_vec("rst_net_do", net_do, 64'h0);
    idle();
    #6 reset = 1'b1;                         // released between edges
    tick();

    // Single packet straight through the output channel
    net_polarity = 1'b0; net_ro = 1'b1;
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'h8000_0000_0000_00A1;
    #1;
    check_vec("t35_so_same_cycle", {63'h0, net_so}, 64'h0);
    tick();
    idle();
    #1;
    check_vec("t35_so",  {63'h0, net_so}, 64'h1);
    check_vec("t35_do",  net_do, 64'h8000_0000_0000_00A1);
    tick();
    check_vec("t35_so_after", {63'h0, net_so}, 64'h0);
    peek(2'b11, v);
    check_vec("t35_cnt0", v, 64'h0);

    // Five pushes with router stalled: fifth overflows
    net_ro = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'h10 + 64'(k);
      tick();
    end
    idle();
    peek(2'b11, v);
    check_vec("t36_stat_full_ovf", v, 64'hC000_0000_0000_0004);
    check_vec("t36_head", net_do, 64'h10);
    check_vec("t36_so_stalled", {63'h0, net_so}, 64'h0);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b11;
    tick();                                  // real status read clears overflow
    idle();
    peek(2'b11, v);
    check_vec("t36_stat_cleared", v, 64'h8000_0000_0000_0004);

    // Full output FIFO, router pop and PE push in the same cycle
    net_ro = 1'b1; net_polarity = 1'b1;
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'h15;
    #1;
    check_vec("t39_so", {63'h0, net_so}, 64'h1);
    tick();
    idle();
    net_ro = 1'b0;
    peek(2'b11, v);
    check_vec("t39_stat", v, 64'h8000_0000_0000_0004);
    drain_exp[0] = 64'h11; drain_exp[1] = 64'h12;
    drain_exp[2] = 64'h13; drain_exp[3] = 64'h15;
    net_ro = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check_vec($sformatf("t39_drain%0d", k), net_do, drain_exp[k]);
      tick();
    end
    check_vec("t39_empty_so", {63'h0, net_so}, 64'h0);
    peek(2'b11, v);
    check_vec("t39_empty_cnt", v, 64'h0);

    // Head waits while its VC bit equals polarity
    net_polarity = 1'b1;
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'h8000_0000_0000_0055;
    tick();
    idle();
    #1;
    check_vec("t38_blocked_so", {63'h0, net_so}, 64'h0);
    check_vec("t38_do", net_do, 64'h8000_0000_0000_0055);
    tick();
    peek(2'b11, v);
    check_vec("t38_still_queued", v, 64'h1);
    net_polarity = 1'b0;
    #1;
    check_vec("t38_so_toggle", {63'h0, net_so}, 64'h1);
    tick();
    peek(2'b11, v);
    check_vec("t38_popped", v, 64'h0);
    net_ro = 1'b0;

    // Router fills the input FIFO, PE drains it
    for (int k = 1; k <= 4; k++) begin
      net_si = 1'b1; net_di = 64'(k);
      #1;
      check_vec($sformatf("t37_ri%0d", k), {63'h0, net_ri}, 64'h1);
      tick();
    end
    check_vec("t37_ri_full", {63'h0, net_ri}, 64'h0);
    net_di = 64'h99;                         // ignored: not ready
    tick();
    net_si = 1'b0;
    peek(2'b01, v);
    check_vec("t37_stat_full", v, 64'h8000_0000_0000_0004);
    for (int k = 1; k <= 4; k++) begin
      nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b00;
      #1;
      check_vec($sformatf("t37_rd%0d", k), d_out, 64'(k));
      if (k == 1) check_vec("t37_ri_no_lookahead", {63'h0, net_ri}, 64'h0);
      tick();
    end
    check_vec("t37_ri_empty", {63'h0, net_ri}, 64'h1);
    #1;
    check_vec("t37_rd_empty", d_out, 64'h0);
    tick();                                  // underflow
    idle();
    peek(2'b01, v);
    check_vec("t37_stat_udf", v, 64'h4000_0000_0000_0000);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b01;
    tick();
    idle();
    peek(2'b01, v);
    check_vec("t37_stat_udf_clr", v, 64'h0);
    nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'h77;
    #1;
    check_vec("t27_dout_on_write", d_out, 64'h0);
    nicEnWr = 1'b0;
    #1;
    check_vec("t27_rd_addr10", d_out, 64'h0);
    idle();

    // Asynchronous reset with traffic queued
    net_ro = 1'b0; net_polarity = 1'b1;
    for (int k = 0; k < 4; k++) begin
      net_si = 1'b1; net_di = 64'h30 + 64'(k);
      if (k < 3) begin
        nicEn = 1'b1; nicEnWr = 1'b1; addr = 2'b10; d_in = 64'h21 + 64'(k);
      end else begin
        nicEn = 1'b0;
      end
      tick();
    end
    idle();
    net_ro = 1'b1;                           // head 0x21 now eligible
    #1;
    check_vec("t40_pre_so", {63'h0, net_so}, 64'h1);
    check_vec("t40_pre_ri", {63'h0, net_ri}, 64'h0);
    reset = 1'b0;
    #1;
    check_vec("t40_so",  {63'h0, net_so}, 64'h0);
    check_vec("t40_ri",  {63'h0, net_ri}, 64'h1);
    check_vec("t40_do",  net_do, 64'h0);
    nicEn = 1'b1; nicEnWr = 1'b0; addr = 2'b00;
    #1;
    check_vec("t40_dout", d_out, 64'h0);
    idle();
    #1 reset = 1'b1;
    tick();
    check_vec("t40_post_so", {63'h0, net_so}, 64'h0);
    check_vec("t40_post_do", net_do, 64'h0);
    peek(2'b11, v);
    check_vec("t40_post_out_stat", v, 64'h0);
    peek(2'b01, v);
    check_vec("t40_post_in_stat", v, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
